// File: rtl/pwm.sv
// pwm: single-channel pulse-width modulator; PERIOD ticks per period, duty latched at the wrap.
// Defining PWM_PRESCALE_EN adds a clock prescaler so a tick occurs every PRESCALE clocks.
module pwm #(
  parameter int PERIOD   = 100,
  parameter int DUTY_W   = 7,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [DUTY_W-1:0] duty_cycle,
  output logic              out
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // duty_q must be able to hold PERIOD itself (constant-high case).
  localparam int DQ_W  = $clog2(PERIOD + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DQ_W-1:0]  DUTY_MAX = DQ_W'(PERIOD);

  if (PERIOD < 2 || PRESCALE < 1) begin : g_param_check
    $error("pwm: PERIOD must be >= 2 and PRESCALE >= 1");
  end

  logic tick;

`ifdef PWM_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  always_comb begin
    tick = (ps_q == PS_LAST);
    ps_d = tick ? '0 : ps_q + PS_W'(1);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DQ_W-1:0]  duty_q, duty_d;
  logic             out_q, out_d;
  logic [DQ_W-1:0]  duty_clamped;
  logic             wrap;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    duty_clamped = (int'(duty_cycle) > PERIOD) ? DUTY_MAX : DQ_W'(duty_cycle);
    wrap         = (cnt_q == CNT_LAST);
    cnt_d        = cnt_q;
    duty_d       = duty_q;
    out_d        = out_q;

    if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) begin
        duty_d = duty_clamped;
      end
      // Compare against the post-edge values so out stays aligned with cnt.
      out_d = (DQ_W'(cnt_d) < duty_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm.sv
// tb_pwm: randomized scoreboard bench for pwm; a period-level reference model predicts out
// for every clock and a monitor compares it against the DUT on the falling edge.
module tb_pwm;

  localparam int PERIOD   = 100;
  localparam int DUTY_W   = 7;
  localparam int PRESCALE = 4;
`ifdef PWM_PRESCALE_EN
  localparam int TICK_DIV = PRESCALE;
`else
  localparam int TICK_DIV = 1;
`endif

  logic              clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DUTY_W-1:0] duty_cycle = '0;
  logic              out;

  int checks   = 0;
  int failures = 0;

  pwm #(.PERIOD(PERIOD), .DUTY_W(DUTY_W), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .duty_cycle (duty_cycle),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clamp(input int x);
    return (x > PERIOD) ? PERIOD : x;
  endfunction

  // Reference model: count clock edges since reset release, derive ticks, and
  // each period's high time from the duty sampled at the previous period's last tick.
  bit sb[$];
  int edges = 0;
  int ticks = 0;
  int model_duty = 0;

  initial begin
    forever begin
      @(posedge clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        edges      = 0;
        ticks      = 0;
        model_duty = 0;
        sb.delete();
      end else begin
        edges++;
        if (edges % TICK_DIV == 0) begin
          ticks++;
          if (ticks % PERIOD == 0) model_duty = clamp(int'(duty_cycle));
        end
        sb.push_back((ticks % PERIOD) < model_duty);
      end
    end
  end

  // Monitor: out is valid every clock; compare away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!sys_rst_n) begin
        check("out_in_reset", int'(out), 0);
      end else if (sb.size() > 0) begin
        check("out_vs_model", int'(out), int'(sb.pop_front()));
      end
    end
  end

  task automatic run_clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int target, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ticks % PERIOD == target && edges % TICK_DIV == 0) found = 1'b1;
    end
    if (!found) check("wait_phase_timeout", 0, 1);
  endtask

  localparam int PCLK = PERIOD * TICK_DIV;

  initial begin
    // Reset held with a non-zero request: out must stay low, even before any edge.
    duty_cycle = 7'd50;
    sys_rst_n  = 1'b0;
    #1;
    check("out_at_time_zero", int'(out), 0);
    run_clocks(10);
    sys_rst_n = 1'b1;
    run_clocks(3 * PCLK);

    // Duty sweep 0..100 in steps of 10, each held two periods.
    for (int d = 0; d <= 100; d += 10) begin
      duty_cycle = DUTY_W'(d);
      run_clocks(2 * PCLK);
    end

    // Mid-period change from 30 to 70 at cnt == 40.
    duty_cycle = 7'd30;
    run_clocks(2 * PCLK);
    wait_phase(40, 2 * PCLK);
    duty_cycle = 7'd70;
    run_clocks(3 * PCLK);

    // Over-range requests behave like PERIOD.
    duty_cycle = 7'd120;
    run_clocks(3 * PCLK);
    duty_cycle = 7'd127;
    run_clocks(2 * PCLK);

    // Random requests changed at arbitrary points in the period.
    repeat (8) begin
      duty_cycle = DUTY_W'($urandom_range(0, 127));
      run_clocks(int'($urandom_range(20, 2 * PCLK)));
    end

    // Asynchronous reset between edges while out is high at cnt == 20, duty 80.
    duty_cycle = 7'd80;
    run_clocks(2 * PCLK);
    wait_phase(20, 2 * PCLK);
    check("out_high_before_async_rst", int'(out), 1);
    @(posedge clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("out_after_async_rst", int'(out), 0);
    run_clocks(5);
    sys_rst_n = 1'b1;
    run_clocks(3 * PCLK);

    run_clocks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Single-channel pulse-width modulator. Generates a fixed-period digital waveform whose high time is set by a duty-cycle input.
- With default parameters, duty_cycle is a percentage (0..100) over a 100-clock period.
- Used as a leaf block driving LEDs, motor enables or similar loads. Duty changes are applied glitch-free, at period boundaries only.

Parameters:
- PERIOD, 100, clocks per PWM period (>=2); internal counter width CNT_W = $clog2(PERIOD) derived locally.
- DUTY_W, 7, width of duty_cycle input.
- PRESCALE, 1, clock divider for counter advance; only honoured when PWM_PRESCALE_EN is defined (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- duty_cycle  input  DUTY_W  requested high time in counter ticks per period (percent at defaults); sampled only at period boundary.
- out  output  1  registered PWM waveform.

Behaviour:
- Reset (sys_rst_n=0, asynchronous): cnt=0, duty_q=0, out=0. Held while low. First period after release is therefore all low.
- Counter: cnt advances by 1 on each tick (every clk edge by default); counts 0..PERIOD-1 then wraps to 0.
- Tick: without PWM_PRESCALE_EN, every rising clk edge is a tick.
- Duty latch:
  - On the tick where cnt == PERIOD-1 (wrap), duty_q <= clamp(duty_cycle), where clamp(x) = PERIOD if x > PERIOD, else x.
  - duty_cycle is ignored at all other times; mid-period changes never alter the current period.
- Output:
  - out is a flop, updated on each tick as out <= (cnt_nxt < duty_q_nxt), using the values cnt and duty_q take on that same edge. out is therefore aligned with cnt and never glitches.
  - Between ticks, out holds.
- Per-period high time: out is high for exactly duty_q ticks, starting at cnt=0. It is low for PERIOD-duty_q ticks.
- Boundary conditions:
  - duty_q=0: out constantly 0 for the whole period.
  - duty_q>=PERIOD: out constantly 1, with no low pulse at the wrap.
  - duty_cycle > PERIOD (e.g. 101..127): treated as PERIOD.
- Latency: a new duty_cycle takes effect at the first cnt=0 following the next wrap. Maximum delay is PERIOD ticks plus one edge.
- Reset mid-period: immediately forces out=0, cnt=0, duty_q=0. Operation restarts as from power-up.
- No combinational path from duty_cycle to out.

Optional Feature:
- Macro PWM_PRESCALE_EN.
- Defined:
  - A prescale counter (reset 0) counts clk edges 0..PRESCALE-1.
  - A tick occurs on the edge where the prescaler wraps; cnt, duty_q and out update only on ticks.
  - Period becomes PERIOD*PRESCALE clocks. PRESCALE=1 is cycle-identical to the macro-undefined build.
- Undefined:
  - No prescaler logic is synthesized; every clk edge is a tick.
  - PRESCALE parameter is accepted but ignored.

Test Plan:
- Reset: sys_rst_n=0 for 10 clocks with duty_cycle=50 -> out=0 throughout. After release, the first 100-clock period is all low. From the following period, out is high for exactly 50 clocks, then low for 50.
- Duty sweep: step duty_cycle 0,10,...,100, each held 200 clocks -> each completed period shows a high count equal to the latched value. 0 gives constant low; 100 gives constant high with no low pulse at the wrap.
- Mid-period change: duty=30 steady, switch to 70 at cnt=40 -> current period stays 30 high. The next period is 70 high; no runt pulse.
- Clamp: duty_cycle=120 -> out stuck high every period, same as 100.
- Async reset mid-period: assert sys_rst_n low at cnt=20 with duty=80, between clock edges -> out falls immediately without waiting for a clock edge. After release, behaviour matches the reset scenario.
- PWM_PRESCALE_EN with PRESCALE=4, duty=25 -> period is 400 clocks; out is high for 100 clocks.
